// File: rtl/hazard_control_unit.sv
// Hazard controller for the RV32 DE pipeline register: stalls, flushes and EX forwarding selects.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit #(
  parameter int unsigned REDIRECT_HOLD = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [4:0]  de_rs1_i,
  input  logic [4:0]  de_rs2_i,
  input  logic [4:0]  de_rd_i,
  input  logic        de_mem_read_i,
  input  logic [4:0]  em_rd_i,
  input  logic        em_reg_write_i,
  input  logic [4:0]  mw_rd_i,
  input  logic        mw_reg_write_i,
  input  logic        ex_redirect_i,
  input  logic        dmem_busy_i,
  output logic        pc_stall_o,
  output logic        fd_stall_o,
  output logic        de_stall_o,
  output logic        em_stall_o,
  output logic        fd_flush_o,
  output logic        de_flush_o,
  output logic [1:0]  fwd_a_sel_o,
  output logic [1:0]  fwd_b_sel_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cycles_o,
  output logic [15:0] flush_events_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [2:0] HOLD_INIT   = REDIRECT_HOLD[2:0];
  localparam logic       HOLD_EN     = (REDIRECT_HOLD != 32'd0);
  localparam logic [1:0] REDIR_NEXT  = HOLD_EN ? ST_REDIRECT : ST_RUN;

  logic [1:0] state_r, state_nxt_s;
  logic [2:0] hold_cnt_r, hold_nxt_s;
  logic       pend_r, pend_nxt_s;
  logic       lu_s;
  logic       pc_stall_s, fd_stall_s, de_stall_s, em_stall_s, fd_flush_s, de_flush_s;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] em_rd,
                                         input logic em_we, input logic [4:0] mw_rd,
                                         input logic mw_we);
    if (em_we && (em_rd != 5'd0) && (em_rd == rs)) begin
      return 2'b01;
    end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == rs)) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  assign fwd_a_sel_o = fwd_sel(de_rs1_i, em_rd_i, em_reg_write_i, mw_rd_i, mw_reg_write_i);
  assign fwd_b_sel_o = fwd_sel(de_rs2_i, em_rd_i, em_reg_write_i, mw_rd_i, mw_reg_write_i);

  assign lu_s = de_mem_read_i && (de_rd_i != 5'd0) &&
                ((id_uses_rs1_i && (id_rs1_i == de_rd_i)) ||
                 (id_uses_rs2_i && (id_rs2_i == de_rd_i)));

  // Control decode and next-state selection; priority is dmem_busy > redirect > load-use.
  always_comb begin
    pc_stall_s  = 1'b0;
    fd_stall_s  = 1'b0;
    de_stall_s  = 1'b0;
    em_stall_s  = 1'b0;
    fd_flush_s  = 1'b0;
    de_flush_s  = 1'b0;
    state_nxt_s = state_r;
    hold_nxt_s  = hold_cnt_r;
    pend_nxt_s  = pend_r;
    case (state_r)
      ST_RUN, ST_MEM_WAIT: begin
        if (dmem_busy_i) begin
          {pc_stall_s, fd_stall_s, de_stall_s, em_stall_s} = 4'b1111;
          state_nxt_s = ST_MEM_WAIT;
          pend_nxt_s  = pend_r | ex_redirect_i;
        end else if (ex_redirect_i || pend_r) begin
          fd_flush_s  = 1'b1;
          de_flush_s  = 1'b1;
          pend_nxt_s  = 1'b0;
          state_nxt_s = REDIR_NEXT;
          hold_nxt_s  = HOLD_INIT;
        end else begin
          pc_stall_s  = lu_s;
          fd_stall_s  = lu_s;
          de_flush_s  = lu_s;
          state_nxt_s = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (dmem_busy_i) begin
          {pc_stall_s, fd_stall_s, de_stall_s, em_stall_s} = 4'b1111;
        end else if (hold_cnt_r <= 3'd1) begin
          fd_flush_s  = 1'b1;
          state_nxt_s = ST_RUN;
          hold_nxt_s  = 3'd0;
        end else begin
          fd_flush_s  = 1'b1;
          hold_nxt_s  = hold_cnt_r - 3'd1;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        hold_nxt_s  = 3'd0;
        pend_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM state, redirect hold counter and deferred-redirect flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_RUN;
      hold_cnt_r <= 3'd0;
      pend_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_nxt_s;
      pend_r     <= pend_nxt_s;
    end
  end

  // Controls are forced quiet while reset is held, even though the inputs may still be active.
  assign pc_stall_o = pc_stall_s & ~rst_i;
  assign fd_stall_o = fd_stall_s & ~rst_i;
  assign de_stall_o = de_stall_s & ~rst_i;
  assign em_stall_o = em_stall_s & ~rst_i;
  assign fd_flush_o = fd_flush_s & ~rst_i;
  assign de_flush_o = de_flush_s & ~rst_i;
  assign state_o    = state_r;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_r, flush_events_r;

  // Saturating performance counters; a redirect is the only action flushing both IF/ID and DE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_r <= 16'd0;
      flush_events_r <= 16'd0;
    end else begin
      if (pc_stall_o && (stall_cycles_r != 16'hFFFF)) begin
        stall_cycles_r <= stall_cycles_r + 16'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (fd_flush_o && de_flush_o && (flush_events_r != 16'hFFFF)) begin
        flush_events_r <= flush_events_r + 16'd1;
      end else begin
        flush_events_r <= flush_events_r;
      end
    end
  end

  assign stall_cycles_o = stall_cycles_r;
  assign flush_events_o = flush_events_r;
`else
  assign stall_cycles_o = 16'd0;
  assign flush_events_o = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed steps plus randomized traffic against a behavioural model.
module tb_hazard_control_unit;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] id_rs1, id_rs2, de_rs1, de_rs2, de_rd, em_rd, mw_rd;
  logic id_uses_rs1, id_uses_rs2, de_mem_read, em_reg_write, mw_reg_write, ex_redirect, dmem_busy;
  logic pc_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel, state;
  logic [15:0] stall_cycles, flush_events;

  hazard_control_unit #(.REDIRECT_HOLD(HOLD)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
    .de_rs1_i(de_rs1), .de_rs2_i(de_rs2), .de_rd_i(de_rd), .de_mem_read_i(de_mem_read),
    .em_rd_i(em_rd), .em_reg_write_i(em_reg_write), .mw_rd_i(mw_rd), .mw_reg_write_i(mw_reg_write),
    .ex_redirect_i(ex_redirect), .dmem_busy_i(dmem_busy),
    .pc_stall_o(pc_stall), .fd_stall_o(fd_stall), .de_stall_o(de_stall), .em_stall_o(em_stall),
    .fd_flush_o(fd_flush), .de_flush_o(de_flush),
    .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel), .state_o(state),
    .stall_cycles_o(stall_cycles), .flush_events_o(flush_events)
  );

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: waiting on memory, cycles left in the redirect window, deferred redirect.
  bit m_wait, m_pend;
  int m_left, m_stalls, m_flushes;

  logic [5:0] obs_ctl;
  logic [1:0] obs_state, obs_fa;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 1'b0; m_pend = 1'b0; m_left = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    de_rs1 = 5'd0; de_rs2 = 5'd0; de_rd = 5'd0; de_mem_read = 1'b0;
    em_rd = 5'd0; em_reg_write = 1'b0; mw_rd = 5'd0; mw_reg_write = 1'b0;
    ex_redirect = 1'b0; dmem_busy = 1'b0;
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (em_reg_write && em_rd != 5'd0 && em_rd == rs) return 2'b01;
    if (mw_reg_write && mw_rd != 5'd0 && mw_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Inputs are already applied (shortly after a rising edge); check, advance the model, cross the edge.
  task automatic cycle();
    logic lu;
    logic [5:0] ctl;
    logic [1:0] st;
    #3;
    lu = de_mem_read && de_rd != 5'd0 &&
         ((id_uses_rs1 && id_rs1 == de_rd) || (id_uses_rs2 && id_rs2 == de_rd));
    st = m_wait ? 2'd1 : (m_left > 0 ? 2'd2 : 2'd0);
    ctl = 6'b000000; // {pc, fd, de, em stall, fd flush, de flush}
    if (m_left > 0) begin
      if (dmem_busy) ctl = 6'b111100;
      else begin ctl = 6'b000010; m_left--; end
    end else if (dmem_busy) begin
      ctl = 6'b111100;
      if (ex_redirect) m_pend = 1'b1;
      m_wait = 1'b1;
    end else if (ex_redirect || m_pend) begin
      ctl = 6'b000011; m_pend = 1'b0; m_left = HOLD; m_wait = 1'b0;
    end else begin
      if (lu) ctl = 6'b110001;
      m_wait = 1'b0;
    end
    obs_ctl = {pc_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush};
    obs_state = state;
    obs_fa = fwd_a_sel;
    check("ctl", 32'(obs_ctl), 32'(ctl));
    check("state", 32'(state), 32'(st));
    check("fwd_a", 32'(fwd_a_sel), 32'(exp_fwd(de_rs1)));
    check("fwd_b", 32'(fwd_b_sel), 32'(exp_fwd(de_rs2)));
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", 32'(stall_cycles), 32'(m_stalls));
    check("flush_cnt", 32'(flush_events), 32'(m_flushes));
`else
    check("stall_cnt_off", 32'(stall_cycles), 32'd0);
    check("flush_cnt_off", 32'(flush_events), 32'd0);
`endif
    if (ctl[5] && m_stalls < 65535) m_stalls++;
    if (ctl[1] && ctl[0] && m_flushes < 65535) m_flushes++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit prev_redir;
    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", 32'({pc_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush}), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0;

    // Load-use bubble, then the bubble removes the hazard.
    de_rd = 5'd5; de_mem_read = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    cycle();
    check("lu_ctl", 32'(obs_ctl), 32'b110001);
    de_rd = 5'd0; de_mem_read = 1'b0;
    cycle();
    check("lu_clear", 32'(obs_ctl), 32'd0);

    // Forwarding priority and the x0 exclusion.
    idle_inputs();
    em_rd = 5'd3; mw_rd = 5'd3; em_reg_write = 1'b1; mw_reg_write = 1'b1; de_rs1 = 5'd3;
    cycle();
    check("fwd_em", 32'(obs_fa), 32'd1);
    em_rd = 5'd0;
    cycle();
    check("fwd_mw", 32'(obs_fa), 32'd2);

    // Redirect window: states 0,2,2,0 with fd_flush for three cycles.
    idle_inputs();
    ex_redirect = 1'b1;
    cycle();
    check("redir_c0", 32'({obs_state, obs_ctl}), 32'({2'd0, 6'b000011}));
    ex_redirect = 1'b0;
    cycle();
    check("redir_c1", 32'({obs_state, obs_ctl}), 32'({2'd2, 6'b000010}));
    cycle();
    check("redir_c2", 32'({obs_state, obs_ctl}), 32'({2'd2, 6'b000010}));
    cycle();
    check("redir_c3", 32'({obs_state, obs_ctl}), 32'({2'd0, 6'b000000}));

    // Four busy cycles with a redirect in the second; redirect happens on release.
    for (int i = 1; i <= 4; i++) begin
      dmem_busy = 1'b1;
      ex_redirect = (i == 2);
      cycle();
      check("busy_stall", 32'(obs_ctl), 32'b111100);
    end
    dmem_busy = 1'b0; ex_redirect = 1'b0;
    cycle();
    check("busy_release", 32'(obs_ctl), 32'b000011);
    repeat (HOLD) cycle();

    // Asynchronous reset in the middle of a memory wait.
    dmem_busy = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    check("async_rst_ctl", 32'({pc_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush}), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle_inputs();

`ifdef HAZARD_PERF_CNT_EN
    de_rd = 5'd7; de_mem_read = 1'b1; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    repeat (3) cycle();
    idle_inputs();
    for (int r = 0; r < 2; r++) begin
      ex_redirect = 1'b1;
      cycle();
      ex_redirect = 1'b0;
      repeat (HOLD + 1) cycle();
    end
    check("perf_stalls", 32'(stall_cycles), 32'd3);
    check("perf_flushes", 32'(flush_events), 32'd2);
    dmem_busy = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    m_wait = 1'b1;
    m_stalls = 65535;
    dmem_busy = 1'b0;
    cycle();
    check("perf_sat", 32'(stall_cycles), 32'hFFFF);
`endif

    // Randomized traffic with a small register range so hazards collide often.
    prev_redir = 1'b0;
    for (int n = 0; n < 400; n++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
      de_rs1 = 5'($urandom_range(0, 3)); de_rs2 = 5'($urandom_range(0, 3));
      de_rd = 5'($urandom_range(0, 3)); de_mem_read = ($urandom_range(0, 2) == 0);
      em_rd = 5'($urandom_range(0, 3)); em_reg_write = 1'($urandom_range(0, 1));
      mw_rd = 5'($urandom_range(0, 3)); mw_reg_write = 1'($urandom_range(0, 1));
      dmem_busy = ($urandom_range(0, 3) == 0);
      ex_redirect = !prev_redir && ($urandom_range(0, 5) == 0);
      prev_redir = ex_redirect;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
